// File: rtl/cirno9_mem_arb.sv
// cirno9_mem_arb
//   N-channel memory-port arbiter. CH val/rdy request channels are serialised
//   onto one SRAM-style port. The winning request is registered at grant.
//   Read data and the completion pulse are routed back to the granted channel.
//
//   Configuration macro CIRNO9_ARB_RR_EN:
//     defined   -> round-robin arbitration starting at a rotating pointer
//     undefined -> fixed priority, lowest channel index wins (no pointer flop)
//
//   Ports:
//     clk, rst_n          clock (rising edge), asynchronous active-low reset
//     i_req_val[CH]       per-channel request valid
//     o_req_rdy[CH]       per-channel completion (transfer on val & rdy)
//     i_req_adr/wdat/wen/ren  packed per-channel request fields
//     o_rdat              read data, zero unless some rdy bit is high
//     o_mem_*             memory port, strobes only active while BUSY
//     i_mem_rdy/i_mem_rdat  memory completion and read data
module cirno9_mem_arb #(
    parameter int  CH = 3,
    parameter int  AW = 32,
    parameter int  DW = 32,
    localparam int WB = DW / 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CH-1:0]      i_req_val,
    output logic [CH-1:0]      o_req_rdy,
    input  logic [CH*AW-1:0]   i_req_adr,
    input  logic [CH*DW-1:0]   i_req_wdat,
    input  logic [CH*WB-1:0]   i_req_wen,
    input  logic [CH-1:0]      i_req_ren,
    output logic [DW-1:0]      o_rdat,
    output logic               o_mem_ren,
    output logic [WB-1:0]      o_mem_wen,
    output logic [AW-1:0]      o_mem_adr,
    output logic [DW-1:0]      o_mem_wdat,
    input  logic               i_mem_rdy,
    input  logic [DW-1:0]      i_mem_rdat
);

    localparam int GW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [AW-1:0]   adr_q,   adr_d;
    logic [DW-1:0]   wdat_q,  wdat_d;
    logic [WB-1:0]   wen_q,   wen_d;
    logic            ren_q,   ren_d;

    // Unpacked views of the per-channel request fields.
    logic [AW-1:0]   req_adr  [CH];
    logic [DW-1:0]   req_wdat [CH];
    logic [WB-1:0]   req_wen  [CH];

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_unpack
            assign req_adr[gi]  = i_req_adr[gi*AW +: AW];
            assign req_wdat[gi] = i_req_wdat[gi*DW +: DW];
            assign req_wen[gi]  = i_req_wen[gi*WB +: WB];
        end
    endgenerate

    // Search start: rotating pointer in round-robin mode, channel 0 otherwise.
    logic [GW-1:0] base;
`ifdef CIRNO9_ARB_RR_EN
    logic [GW-1:0] ptr_q, ptr_d;
    assign base = ptr_q;
`else
    assign base = '0;
`endif

    // Scan offsets from high to low so the requester closest to base wins.
    logic [GW-1:0] pick;
    logic [GW:0]   idx_sum;
    logic [GW-1:0] idx;
    always_comb begin
        pick    = '0;
        idx_sum = '0;
        idx     = '0;
        for (int k = CH - 1; k >= 0; k--) begin
            idx_sum = {1'b0, base} + (GW+1)'(k);
            if (idx_sum >= (GW+1)'(CH)) begin
                idx_sum = idx_sum - (GW+1)'(CH);
            end
            idx = idx_sum[GW-1:0];
            if (i_req_val[idx]) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        wen_d   = wen_q;
        ren_d   = ren_q;
`ifdef CIRNO9_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|i_req_val) begin
                    grant_d = pick;
                    adr_d   = req_adr[pick];
                    wdat_d  = req_wdat[pick];
                    wen_d   = req_wen[pick];
                    ren_d   = i_req_ren[pick];
                    state_d = BUSY;
`ifdef CIRNO9_ARB_RR_EN
                    ptr_d   = (pick == GW'(CH - 1)) ? '0 : pick + GW'(1);
`endif
                end
            end
            BUSY: begin
                if (i_mem_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            wen_q   <= '0;
            ren_q   <= 1'b0;
`ifdef CIRNO9_ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            wen_q   <= wen_d;
            ren_q   <= ren_d;
`ifdef CIRNO9_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    logic busy;
    logic done;
    assign busy = (state_q == BUSY);
    assign done = busy & i_mem_rdy;

    // Address/data follow the registered request; only the strobes are gated.
    assign o_mem_ren  = busy & ren_q;
    assign o_mem_wen  = busy ? wen_q : '0;
    assign o_mem_adr  = adr_q;
    assign o_mem_wdat = wdat_q;
    assign o_rdat     = done ? i_mem_rdat : '0;

    generate
        for (gi = 0; gi < CH; gi++) begin : g_rdy
            assign o_req_rdy[gi] = done && (grant_q == GW'(gi));
        end
    endgenerate

endmodule

// File: tb/tb_cirno9_mem_arb.sv
// Testbench for cirno9_mem_arb: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_cirno9_mem_arb;

    localparam int CH = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WB = DW / 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [CH-1:0]      i_req_val;
    logic [CH-1:0]      o_req_rdy;
    logic [CH*AW-1:0]   i_req_adr;
    logic [CH*DW-1:0]   i_req_wdat;
    logic [CH*WB-1:0]   i_req_wen;
    logic [CH-1:0]      i_req_ren;
    logic [DW-1:0]      o_rdat;
    logic               o_mem_ren;
    logic [WB-1:0]      o_mem_wen;
    logic [AW-1:0]      o_mem_adr;
    logic [DW-1:0]      o_mem_wdat;
    logic               i_mem_rdy;
    logic [DW-1:0]      i_mem_rdat;

    cirno9_mem_arb #(.CH(CH), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req_val  (i_req_val),
        .o_req_rdy  (o_req_rdy),
        .i_req_adr  (i_req_adr),
        .i_req_wdat (i_req_wdat),
        .i_req_wen  (i_req_wen),
        .i_req_ren  (i_req_ren),
        .o_rdat     (o_rdat),
        .o_mem_ren  (o_mem_ren),
        .o_mem_wen  (o_mem_wen),
        .o_mem_adr  (o_mem_adr),
        .o_mem_wdat (o_mem_wdat),
        .i_mem_rdy  (i_mem_rdy),
        .i_mem_rdat (i_mem_rdat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one outstanding transaction, captured at grant.
    bit             m_busy;
    int             m_g;
    int             m_ptr;
    logic [AW-1:0]  m_adr;
    logic [DW-1:0]  m_wdat;
    logic [WB-1:0]  m_wen;
    logic           m_ren;
    logic [CH-1:0]  last_rdy;
    int             grant_log[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First requesting channel at or after the start point, wrapping mod CH.
    function automatic int ref_pick(input logic [CH-1:0] v, input int start);
        for (int k = 0; k < CH; k++) begin
            if (v[(start + k) % CH]) return (start + k) % CH;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy   = 0;
        m_g      = 0;
        m_ptr    = 0;
        last_rdy = '0;
    endtask

    task automatic settle_check();
        logic [CH-1:0] exp_rdy;
        #1;
        exp_rdy = (m_busy && i_mem_rdy) ? (CH'(1) << m_g) : '0;
        check_val("rdy", o_req_rdy, exp_rdy);
        check_val("rdat", o_rdat, (exp_rdy != 0) ? i_mem_rdat : '0);
        check_val("mem_ren", o_mem_ren, m_busy ? m_ren : 1'b0);
        check_val("mem_wen", o_mem_wen, m_busy ? m_wen : '0);
        if (m_busy) begin
            check_val("mem_adr", o_mem_adr, m_adr);
            check_val("mem_wdat", o_mem_wdat, m_wdat);
        end
        last_rdy = exp_rdy;
    endtask

    task automatic tick();
        int g;
        @(posedge clk);
        if (rst_n) begin
            if (!m_busy) begin
                if (|i_req_val) begin
`ifdef CIRNO9_ARB_RR_EN
                    g = ref_pick(i_req_val, m_ptr);
`else
                    g = ref_pick(i_req_val, 0);
`endif
                    m_g    = g;
                    m_adr  = i_req_adr[g*AW +: AW];
                    m_wdat = i_req_wdat[g*DW +: DW];
                    m_wen  = i_req_wen[g*WB +: WB];
                    m_ren  = i_req_ren[g];
                    m_ptr  = (g + 1) % CH;
                    m_busy = 1;
                end
            end else if (i_mem_rdy) begin
                m_busy = 0;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        i_req_val  = '0;
        i_req_adr  = '0;
        i_req_wdat = '0;
        i_req_wen  = '0;
        i_req_ren  = '0;
        i_mem_rdy  = 1'b0;
        i_mem_rdat = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_rdy", o_req_rdy, '0);
        check_val("rst_rdat", o_rdat, '0);
        check_val("rst_ren", o_mem_ren, 1'b0);
        check_val("rst_wen", o_mem_wen, '0);
        check_val("rst_adr", o_mem_adr, '0);
        check_val("rst_wdat", o_mem_wdat, '0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_order[6];
        rst_n = 1'b0;
        model_reset();
        clear_inputs();

        // Single channel 1 read, memory always ready.
        do_reset();
        i_req_val = 3'b010;
        i_req_ren = 3'b010;
        i_req_adr[1*AW +: AW] = 32'h100;
        i_mem_rdy  = 1'b1;
        i_mem_rdat = 32'hDEADBEEF;
        settle_check();
        check_val("t1_c0_rdy", o_req_rdy, 3'b000);
        tick();
        settle_check();
        check_val("t1_ren", o_mem_ren, 1'b1);
        check_val("t1_adr", o_mem_adr, 32'h100);
        check_val("t1_rdy", o_req_rdy, 3'b010);
        check_val("t1_rdat", o_rdat, 32'hDEADBEEF);
        tick();
        i_req_val = '0;
        settle_check();
        check_val("t1_idle_ren", o_mem_ren, 1'b0);
        check_val("t1_idle_rdy", o_req_rdy, 3'b000);

        // Channel 2 write with a memory that stalls for three cycles.
        do_reset();
        i_req_val = 3'b100;
        i_req_adr[2*AW +: AW]  = 32'h200;
        i_req_wdat[2*DW +: DW] = 32'h12345678;
        i_req_wen[2*WB +: WB]  = 4'b0011;
        settle_check();
        tick();
        for (int b = 1; b <= 4; b++) begin
            i_mem_rdy = (b == 4);
            settle_check();
            check_val("t2_adr", o_mem_adr, 32'h200);
            check_val("t2_wdat", o_mem_wdat, 32'h12345678);
            check_val("t2_wen", o_mem_wen, 4'b0011);
            check_val("t2_rdy", o_req_rdy, (b == 4) ? 3'b100 : 3'b000);
            tick();
        end
        i_req_val = '0;
        settle_check();
        check_val("t2_after_rdy", o_req_rdy, 3'b000);

        // All channels requesting continuously.
        do_reset();
        i_req_val = 3'b111;
        i_req_ren = 3'b111;
        i_mem_rdy = 1'b1;
        for (int c = 0; c < CH; c++) i_req_adr[c*AW +: AW] = 32'h1000 + c;
        grant_log.delete();
        for (int i = 0; i < 13; i++) begin
            settle_check();
            for (int c = 0; c < CH; c++) if (o_req_rdy[c]) grant_log.push_back(c);
            tick();
        end
`ifdef CIRNO9_ARB_RR_EN
        exp_order = '{0, 1, 2, 0, 1, 2};
`else
        exp_order = '{0, 0, 0, 0, 0, 0};
`endif
        check_val("t3_grants", (grant_log.size() >= 6) ? 1 : 0, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) check_val("t3_order", grant_log[i], exp_order[i]);
        end

        // Field change and val drop while BUSY.
        do_reset();
        i_req_val = 3'b001;
        i_req_ren = 3'b001;
        i_req_adr[0 +: AW] = 32'h40;
        settle_check();
        tick();
        i_req_adr[0 +: AW] = 32'h80;
        settle_check();
        check_val("t4_adr_hold", o_mem_adr, 32'h40);
        tick();
        i_req_val = '0;
        settle_check();
        check_val("t4_adr_drop", o_mem_adr, 32'h40);
        tick();
        i_mem_rdy = 1'b1;
        settle_check();
        check_val("t4_rdy", o_req_rdy, 3'b001);
        tick();
        settle_check();
        check_val("t4_once", o_req_rdy, 3'b000);

        // Reset asserted in the middle of BUSY.
        do_reset();
        i_req_val = 3'b010;
        i_req_ren = 3'b010;
        i_req_adr[1*AW +: AW] = 32'h55;
        settle_check();
        tick();
        i_mem_rdy  = 1'b1;
        i_mem_rdat = 32'hCAFEF00D;
        settle_check();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("t5_rdy", o_req_rdy, '0);
        check_val("t5_rdat", o_rdat, '0);
        check_val("t5_ren", o_mem_ren, 1'b0);
        check_val("t5_wen", o_mem_wen, '0);
        i_req_val = 3'b111;
        i_req_ren = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        settle_check();
        tick();
        settle_check();
        check_val("t5_first_grant", o_req_rdy, 3'b001);
        tick();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < CH; c++) begin
                if (last_rdy[c]) begin
                    i_req_val[c] = 1'b0;
                end else if (m_busy && m_g == c && $urandom_range(0, 5) == 0) begin
                    if ($urandom_range(0, 1) == 0) i_req_val[c] = 1'b0;
                    else i_req_adr[c*AW +: AW] = $urandom;
                end
                if (!i_req_val[c] && !(m_busy && m_g == c) && !last_rdy[c]
                    && $urandom_range(0, 2) == 0) begin
                    i_req_val[c] = 1'b1;
                    i_req_adr[c*AW +: AW]  = $urandom;
                    i_req_wdat[c*DW +: DW] = $urandom;
                    i_req_wen[c*WB +: WB]  = WB'($urandom);
                    i_req_ren[c]           = 1'($urandom);
                end
            end
            i_mem_rdy  = 1'($urandom_range(0, 1));
            i_mem_rdat = $urandom;
            settle_check();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cirno9_mem_arb.md
# cirno9_mem_arb

Parametrised N-channel memory-port arbiter for the cirno9 core, the generalised successor to the fixed fetch/execute/slave selection in the current load-store path. It accepts CH independent val/rdy request channels (instruction fetch, load/store, external slave, DMA, ...) and serialises them onto one SRAM-style port. Each transaction is registered on grant, and the read data and completion pulse are routed back to the granted channel. Channel selection is fixed-priority or round-robin, chosen at compile time.

## Interface
Parameters:
- CH, 3, number of request channels (≥2)
- AW, 32, address width
- DW, 32, data width (multiple of 8); WB = DW/8 byte enables

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req_val  in  CH  per-channel request valid
- o_req_rdy  out  CH  per-channel completion; transfer on val & rdy
- i_req_adr  in  CH*AW  channel c at [c*AW +: AW]
- i_req_wdat  in  CH*DW  channel c at [c*DW +: DW]
- i_req_wen  in  CH*WB  per-channel byte write enables
- i_req_ren  in  CH  per-channel read enable
- o_rdat  out  DW  read data, valid while any o_req_rdy bit is high
- o_mem_ren  out  1  memory read strobe
- o_mem_wen  out  WB  memory byte write strobes
- o_mem_adr  out  AW  memory address
- o_mem_wdat  out  DW  memory write data
- i_mem_rdy  in  1  memory completes the current access
- i_mem_rdat  in  DW  memory read data, valid with i_mem_rdy

## Operation
- Two states: IDLE and BUSY.
- IDLE, no i_req_val bit set: remain in IDLE.
- IDLE, any i_req_val bit set:
  - pick grant index g per the priority scheme
  - register adr/wdat/wen/ren of channel g
  - store g and go to BUSY
- BUSY:
  - o_mem_adr/wdat/wen/ren are driven from the registered request
  - o_mem_ren/o_mem_wen are forced 0 outside BUSY
- BUSY, i_mem_rdy=1:
  - o_req_rdy[g]=1 combinationally; all other rdy bits 0
  - o_rdat = i_mem_rdat
  - next state IDLE
- BUSY, i_mem_rdy=0: hold all memory outputs unchanged.
- A requester holds val and fields until it sees rdy. Fields are sampled only at grant, so later field changes are ignored. If val drops while BUSY, the access still completes and the rdy pulse is still issued.
- A request with ren=0 and wen=0 is forwarded and completed like any other.
- o_rdat is 0 whenever no rdy bit is high.
- Only one channel is granted at a time, and exactly one o_req_rdy pulse is issued per grant.

## Timing
- Reset values: state IDLE, all registered request fields 0, grant 0, RR pointer 0. All outputs are 0, including o_req_rdy, o_rdat and the memory strobes.
- Minimum latency: val seen in IDLE at cycle 0 → BUSY at cycle 1 → rdy at cycle 1 if i_mem_rdy=1. Each access therefore takes ≥2 cycles.
- The earliest next grant is the IDLE cycle after completion. This gives one bubble per access, so peak throughput is 1 access per 2 cycles.
- Reset asserted mid-BUSY immediately drops the memory strobes and rdy. No completion pulse is issued for the aborted access.

## Configuration
- Macro CIRNO9_ARB_RR_EN.
- Defined: round-robin arbitration.
  - Search starts at pointer p and wraps modulo CH.
  - On each grant, p ← (g+1) mod CH; when g=CH-1, p wraps to 0.
  - Any continuously requesting channel is granted within CH grants.
- Undefined: fixed priority, lowest index wins; the pointer register is not built.

## Test plan
- Single channel 1 read of adr 0x100, memory returns 0xDEADBEEF with i_mem_rdy tied 1:
  - o_mem_ren=1 in cycle 1
  - o_req_rdy=3'b010 and o_rdat=0xDEADBEEF in cycle 1
  - IDLE in cycle 2
- Channel 2 write, wdat 0x12345678, wen 4'b0011, i_mem_rdy held low for 3 BUSY cycles:
  - adr/wdat/wen stable throughout
  - one rdy pulse on bit 2 on the 4th BUSY cycle
- All three channels valid continuously:
  - with RR_EN, grant order is 0,1,2,0,1,2
  - without RR_EN, channel 0 is granted every time
- Channel 0 changes adr while BUSY, then drops val before i_mem_rdy:
  - o_mem_adr keeps the originally granted value
  - rdy[0] still pulses once
- rst_n pulsed low in the middle of BUSY:
  - all outputs go 0 asynchronously
  - after release, the first grant goes to channel 0 with RR pointer 0
